// File: rtl/ssp_cmd_master_if.sv
// Command, response and SSP frame signals between ssp_cmd_master and its neighbours.
// The master modport is the ssp_cmd_master side; slave is the environment side.
interface ssp_cmd_master_if;
   localparam int unsigned RA_W = 3;
   localparam int unsigned D_W  = 12;

   logic            cmd_valid;
   logic            cmd_ready;
   logic [RA_W-1:0] cmd_ra;
   logic            cmd_wnr;
   logic [D_W-1:0]  cmd_di;

   logic            rsp_valid;
   logic            rsp_ready;
   logic [RA_W-1:0] rsp_ra;
   logic [D_W-1:0]  rsp_do;

   logic            SSP_SSEL;
   logic [RA_W-1:0] SSP_RA;
   logic            SSP_WnR;
   logic [D_W-1:0]  SSP_DI;
   logic            SSP_EOC;
   logic [D_W-1:0]  SSP_DO;

   modport master (
      input  cmd_valid, cmd_ra, cmd_wnr, cmd_di, rsp_ready, SSP_DO,
      output cmd_ready, rsp_valid, rsp_ra, rsp_do,
             SSP_SSEL, SSP_RA, SSP_WnR, SSP_DI, SSP_EOC
   );

   modport slave (
      output cmd_valid, cmd_ra, cmd_wnr, cmd_di, rsp_ready, SSP_DO,
      input  cmd_ready, rsp_valid, rsp_ra, rsp_do,
             SSP_SSEL, SSP_RA, SSP_WnR, SSP_DI, SSP_EOC
   );
endinterface

// File: rtl/ssp_cmd_master.sv
// SSP bus master for ssp_uart: queues register-access commands and plays each one
// out as an SSEL/EOC frame, returning captured read data on a response channel.
module ssp_cmd_master #(
   parameter  int unsigned FIFO_DEPTH = 4,
   parameter  int unsigned SETUP_CYC  = 1,
   parameter  int unsigned GAP_CYC    = 1,
   localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             Clk,
   input  logic             Rst,
   ssp_cmd_master_if.master bus,
   output logic             busy,
   output logic [CW-1:0]    fifo_count
);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned SW   = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
   localparam int unsigned GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int unsigned RA_W = 3;
   localparam int unsigned D_W  = 12;

   typedef struct packed {
      logic [RA_W-1:0] ra;
      logic            wnr;
      logic [D_W-1:0]  di;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_GAP} state_t;

   state_t          state;
   cmd_t            mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            head_vld;
   logic [SW-1:0]   setup_cnt;
   logic [GW-1:0]   gap_cnt;

   logic            ssel;
   logic            eoc;
   logic [RA_W-1:0] ra;
   logic            wnr;
   logic [D_W-1:0]  di;

   logic            rsp_valid;
   logic [RA_W-1:0] rsp_ra;
   logic [D_W-1:0]  rsp_do;

   cmd_t            head;
   logic            full;
   logic            cmd_ready;
   logic            push;
   logic            pop;

   // Full is judged on the current count, so a same-cycle pop never frees a slot early.
   assign full      = (count == CW'(FIFO_DEPTH));
   assign cmd_ready = Rst && !full;
   assign push      = bus.cmd_valid && cmd_ready;
   assign head      = mem[rd_ptr];

   // A read at the head waits for the response slot; writes always proceed.
   assign pop = (state == S_IDLE) && head_vld && (head.wnr || !rsp_valid);

   // Command storage; entries are only meaningful between the pointers.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr] <= '{ra: bus.cmd_ra, wnr: bus.cmd_wnr, di: bus.cmd_di};
      end
   end

   // Pointers, occupancy, frame sequencer and response register.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         head_vld  <= 1'b0;
         setup_cnt <= '0;
         gap_cnt   <= '0;
         ssel      <= 1'b0;
         eoc       <= 1'b0;
         ra        <= '0;
         wnr       <= 1'b0;
         di        <= '0;
         rsp_valid <= 1'b0;
         rsp_ra    <= '0;
         rsp_do    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);

         // Non-empty as seen one cycle late: a new entry is issued from the cycle after it
         // lands. Pops are at least three cycles apart, so the lag never over-reports.
         head_vld <= (count != '0);

         if (rsp_valid && bus.rsp_ready) begin
            rsp_valid <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               ssel <= 1'b0;
               eoc  <= 1'b0;
               if (pop) begin
                  ra        <= head.ra;
                  wnr       <= head.wnr;
                  di        <= head.wnr ? head.di : '0;
                  ssel      <= 1'b1;
                  setup_cnt <= '0;
                  state     <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (setup_cnt == SW'(SETUP_CYC - 1)) begin
                  eoc   <= 1'b1;
                  state <= S_XFER;
               end else begin
                  setup_cnt <= setup_cnt + SW'(1);
               end
            end

            S_XFER: begin
               eoc  <= 1'b0;
               ssel <= 1'b0;
               if (!wnr) begin
                  rsp_do    <= bus.SSP_DO;
                  rsp_ra    <= ra;
                  rsp_valid <= 1'b1;
               end
               if (GAP_CYC != 0) begin
                  gap_cnt <= '0;
                  state   <= S_GAP;
               end else begin
                  state <= S_IDLE;
               end
            end

            S_GAP: begin
               if (gap_cnt == GW'(GAP_CYC - 1)) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_ra    = rsp_ra;
   assign bus.rsp_do    = rsp_do;
   assign bus.SSP_SSEL  = ssel;
   assign bus.SSP_RA    = ra;
   assign bus.SSP_WnR   = wnr;
   assign bus.SSP_DI    = di;
   assign bus.SSP_EOC   = eoc;

   assign fifo_count = count;
   assign busy       = (state != S_IDLE) || (count != '0);
endmodule

// File: tb/tb_ssp_cmd_master.sv
// Bench for ssp_cmd_master: a table of single-command frames plus hand-written
// sequences for FIFO fill, read stalls, mid-frame reset and a no-gap configuration.
`timescale 1ns/1ps
module tb_ssp_cmd_master;
   typedef struct {
      int              start;
      int              len;
      int              eoc_pos;
      int              eoc_cnt;
      logic [2:0]      ra;
      logic            wnr;
      logic [11:0]     di;
      bit              stable;
   } frame_t;

   typedef struct {
      logic [2:0]  ra;
      logic [11:0] d;
      int          cyc;
   } rsp_t;

   typedef struct {
      logic [2:0]  ra;
      logic        wnr;
      logic [11:0] di;
      logic [11:0] exp_di;
      logic [11:0] exp_do;
   } vec_t;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        busy_a, busy_b;
   logic [2:0]  cnt_a, cnt_b;
   logic [11:0] regs [8];

   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          eoc_total = 0;
   frame_t      frames [$];
   rsp_t        rsp_q [$];
   vec_t        vt [6];

   ssp_cmd_master_if a_if ();
   ssp_cmd_master_if b_if ();

   ssp_cmd_master #(.FIFO_DEPTH(4), .SETUP_CYC(1), .GAP_CYC(1)) dut_a (
      .Clk(Clk), .Rst(Rst), .bus(a_if.master), .busy(busy_a), .fifo_count(cnt_a));

   ssp_cmd_master #(.FIFO_DEPTH(4), .SETUP_CYC(3), .GAP_CYC(0)) dut_b (
      .Clk(Clk), .Rst(Rst), .bus(b_if.master), .busy(busy_b), .fifo_count(cnt_b));

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // ssp_uart stand-in: register file read combinationally, written on a write EOC.
   assign a_if.SSP_DO = regs[a_if.SSP_RA];
   assign b_if.SSP_DO = 12'h000;

   function automatic void chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endfunction

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic push_a(input logic [2:0] ra, input logic wnr, input logic [11:0] di,
                         output int pe);
      int n;
      n = 0;
      a_if.cmd_valid = 1'b1;
      a_if.cmd_ra    = ra;
      a_if.cmd_wnr   = wnr;
      a_if.cmd_di    = di;
      while (!a_if.cmd_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) timeout("push_ready");
      step();
      pe = cyc;
      a_if.cmd_valid = 1'b0;
   endtask

   task automatic get_frame(input string name, output frame_t f, output bit ok);
      int n;
      n = 0;
      while (frames.size() == 0 && n < 100) begin
         step();
         n++;
      end
      ok = (frames.size() != 0);
      f  = '{default: 0};
      if (ok) f = frames.pop_front();
      else timeout(name);
   endtask

   task automatic wait_rsp(input string name, input int k);
      int n;
      n = 0;
      while (rsp_q.size() < k && n < 100) begin
         step();
         n++;
      end
      if (rsp_q.size() < k) timeout(name);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy_a || busy_b || a_if.rsp_valid) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) timeout("wait_idle");
   endtask

   // Frame and response recorder for dut_a, sampled mid-cycle.
   initial begin : monitor
      frame_t cur;
      bit     in_fr;
      logic   prev_rsp;
      in_fr    = 1'b0;
      prev_rsp = 1'b0;
      cur      = '{default: 0};
      for (int i = 0; i < 8; i++) regs[i] = 12'(12'h111 * i);
      regs[3] = 12'h5A5;
      forever begin
         @(negedge Clk);
         if (a_if.SSP_EOC) eoc_total++;
         if (a_if.SSP_SSEL && a_if.SSP_EOC && a_if.SSP_WnR) regs[a_if.SSP_RA] = a_if.SSP_DI;
         if (a_if.SSP_SSEL) begin
            if (!in_fr) begin
               in_fr       = 1'b1;
               cur.start   = cyc;
               cur.len     = 0;
               cur.eoc_cnt = 0;
               cur.eoc_pos = -1;
               cur.ra      = a_if.SSP_RA;
               cur.wnr     = a_if.SSP_WnR;
               cur.di      = a_if.SSP_DI;
               cur.stable  = 1'b1;
            end
            if (a_if.SSP_RA != cur.ra || a_if.SSP_WnR != cur.wnr || a_if.SSP_DI != cur.di)
               cur.stable = 1'b0;
            if (a_if.SSP_EOC) begin
               cur.eoc_cnt++;
               cur.eoc_pos = cur.len;
            end
            cur.len++;
         end else if (in_fr) begin
            in_fr = 1'b0;
            frames.push_back(cur);
         end
         if (a_if.rsp_valid && !prev_rsp)
            rsp_q.push_back('{ra: a_if.rsp_ra, d: a_if.rsp_do, cyc: cyc});
         prev_rsp = a_if.rsp_valid;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      frame_t      f;
      bit          ok;
      int          pe, n, prev_start, eo;
      rsp_t        r;
      logic [4:0]  rdy;
      logic [11:0] ssel_v, eoc_v, di1, di2;
      logic [11:0] t3_do [5];

      vt[0] = '{3'd0, 1'b1, 12'hDED, 12'hDED, 12'h000};
      vt[1] = '{3'd3, 1'b0, 12'hFFF, 12'h000, 12'h5A5};
      vt[2] = '{3'd5, 1'b1, 12'h123, 12'h123, 12'h000};
      vt[3] = '{3'd5, 1'b0, 12'h0F0, 12'h000, 12'h123};
      vt[4] = '{3'd7, 1'b1, 12'hFFF, 12'hFFF, 12'h000};
      vt[5] = '{3'd0, 1'b0, 12'h000, 12'h000, 12'hDED};
      t3_do = '{12'h111, 12'h222, 12'h5A5, 12'h444, 12'h123};

      a_if.cmd_valid = 1'b0; a_if.cmd_ra = '0; a_if.cmd_wnr = 1'b0; a_if.cmd_di = '0;
      a_if.rsp_ready = 1'b0;
      b_if.cmd_valid = 1'b0; b_if.cmd_ra = '0; b_if.cmd_wnr = 1'b0; b_if.cmd_di = '0;
      b_if.rsp_ready = 1'b1;

      // Reset state
      step(3);
      chk("rst_ssel", a_if.SSP_SSEL, 0);
      chk("rst_eoc", a_if.SSP_EOC, 0);
      chk("rst_di", a_if.SSP_DI, 0);
      chk("rst_cmd_ready", a_if.cmd_ready, 0);
      chk("rst_rsp_valid", a_if.rsp_valid, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_count", cnt_a, 0);
      Rst = 1'b1;
      #1;
      chk("rel_cmd_ready", a_if.cmd_ready, 1);
      step(2);

      // Single-command frames from the vector table
      for (int i = 0; i < 6; i++) begin
         wait_idle();
         push_a(vt[i].ra, vt[i].wnr, vt[i].di, pe);
         get_frame($sformatf("v%0d_frame", i), f, ok);
         if (ok) begin
            chk($sformatf("v%0d_latency", i), f.start - pe, 2);
            chk($sformatf("v%0d_ssel_len", i), f.len, 2);
            chk($sformatf("v%0d_eoc_cnt", i), f.eoc_cnt, 1);
            chk($sformatf("v%0d_eoc_pos", i), f.eoc_pos, 1);
            chk($sformatf("v%0d_ra", i), f.ra, vt[i].ra);
            chk($sformatf("v%0d_wnr", i), f.wnr, vt[i].wnr);
            chk($sformatf("v%0d_di", i), f.di, vt[i].exp_di);
            chk($sformatf("v%0d_stable", i), f.stable, 1);
         end
         step(3);
         chk($sformatf("v%0d_hold_di", i), a_if.SSP_DI, vt[i].exp_di);
         if (vt[i].wnr) begin
            chk($sformatf("v%0d_no_rsp", i), rsp_q.size(), 0);
         end else begin
            wait_rsp($sformatf("v%0d_rsp", i), 1);
            if (rsp_q.size() != 0) begin
               r = rsp_q.pop_front();
               chk($sformatf("v%0d_rsp_lat", i), r.cyc - f.start, 2);
               chk($sformatf("v%0d_rsp_ra", i), r.ra, vt[i].ra);
               chk($sformatf("v%0d_rsp_do", i), r.d, vt[i].exp_do);
            end
            chk($sformatf("v%0d_rsp_held", i), a_if.rsp_valid, 1);
            a_if.rsp_ready = 1'b1;
            step();
            chk($sformatf("v%0d_rsp_clr", i), a_if.rsp_valid, 0);
            a_if.rsp_ready = 1'b0;
         end
      end

      // FIFO fill behind a stalled read, then in-order drain at minimum spacing
      wait_idle();
      push_a(3'd6, 1'b0, 12'h000, pe);
      get_frame("t3_lead_frame", f, ok);
      wait_rsp("t3_lead_rsp", 1);
      if (rsp_q.size() != 0) begin
         r = rsp_q.pop_front();
         chk("t3_lead_do", r.d, 12'h666);
      end
      rdy = '0;
      for (int i = 0; i < 5; i++) begin
         a_if.cmd_valid = 1'b1;
         a_if.cmd_ra    = 3'(i + 1);
         a_if.cmd_wnr   = 1'b0;
         a_if.cmd_di    = 12'h000;
         rdy[i]         = a_if.cmd_ready;
         step();
      end
      chk("t3_ready_pattern", rdy, 5'b01111);
      chk("t3_count_full", cnt_a, 4);
      step(3);
      chk("t3_count_hold", cnt_a, 4);
      chk("t3_ready_low", a_if.cmd_ready, 0);
      chk("t3_no_frame", frames.size(), 0);
      a_if.rsp_ready = 1'b1;
      n = 0;
      while (!a_if.cmd_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) timeout("t3_fifth_push");
      step();
      a_if.cmd_valid = 1'b0;
      prev_start = 0;
      for (int i = 0; i < 5; i++) begin
         get_frame("t3_frame", f, ok);
         if (ok) begin
            chk($sformatf("t3_ra%0d", i), f.ra, i + 1);
            chk($sformatf("t3_wnr%0d", i), f.wnr, 0);
            if (i > 0) chk($sformatf("t3_spacing%0d", i), f.start - prev_start, 4);
            prev_start = f.start;
         end
      end
      wait_rsp("t3_rsp", 5);
      for (int i = 0; i < 5; i++) begin
         if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            chk($sformatf("t3_rsp_ra%0d", i), r.ra, i + 1);
            chk($sformatf("t3_rsp_do%0d", i), r.d, t3_do[i]);
         end
      end

      // Second read stalls on the pending response and the write waits behind it
      wait_idle();
      a_if.rsp_ready = 1'b0;
      push_a(3'd1, 1'b0, 12'h000, pe);
      push_a(3'd2, 1'b0, 12'h000, pe);
      push_a(3'd4, 1'b1, 12'hABC, pe);
      step(15);
      chk("t4_one_frame", frames.size(), 1);
      chk("t4_count", cnt_a, 2);
      chk("t4_busy", busy_a, 1);
      chk("t4_rsp_valid", a_if.rsp_valid, 1);
      chk("t4_rsp_ra", a_if.rsp_ra, 1);
      chk("t4_rsp_do", a_if.rsp_do, 12'h111);
      get_frame("t4_f0", f, ok);
      if (ok) chk("t4_f0_ra", f.ra, 1);
      a_if.rsp_ready = 1'b1;
      get_frame("t4_f1", f, ok);
      if (ok) begin
         chk("t4_f1_ra", f.ra, 2);
         chk("t4_f1_wnr", f.wnr, 0);
      end
      get_frame("t4_f2", f, ok);
      if (ok) begin
         chk("t4_f2_ra", f.ra, 4);
         chk("t4_f2_wnr", f.wnr, 1);
         chk("t4_f2_di", f.di, 12'hABC);
      end
      wait_rsp("t4_rsp", 2);
      if (rsp_q.size() >= 2) begin
         r = rsp_q.pop_front();
         chk("t4_rsp0_ra", r.ra, 1);
         r = rsp_q.pop_front();
         chk("t4_rsp1_ra", r.ra, 2);
         chk("t4_rsp1_do", r.d, 12'h222);
      end

      // Reset during SETUP of a write with another write queued
      wait_idle();
      eo = eoc_total;
      push_a(3'd2, 1'b1, 12'h777, pe);
      push_a(3'd3, 1'b1, 12'h888, pe);
      step();
      chk("t5_in_setup", a_if.SSP_SSEL, 1);
      Rst = 1'b0;
      #1;
      chk("t5_ready_low_now", a_if.cmd_ready, 0);
      step();
      chk("t5_ssel", a_if.SSP_SSEL, 0);
      chk("t5_eoc", a_if.SSP_EOC, 0);
      chk("t5_count", cnt_a, 0);
      chk("t5_busy", busy_a, 0);
      chk("t5_di", a_if.SSP_DI, 0);
      chk("t5_wnr", a_if.SSP_WnR, 0);
      step(2);
      chk("t5_ready_held", a_if.cmd_ready, 0);
      Rst = 1'b1;
      #1;
      chk("t5_ready_rel", a_if.cmd_ready, 1);
      step(10);
      chk("t5_eoc_never", eoc_total - eo, 0);
      chk("t5_frames", frames.size(), 1);
      if (frames.size() != 0) begin
         f = frames.pop_front();
         chk("t5_abort_len", f.len, 1);
         chk("t5_abort_eoc", f.eoc_cnt, 0);
      end
      chk("t5_count_after", cnt_a, 0);

      // No-gap, three-cycle setup configuration on dut_b
      b_if.cmd_valid = 1'b1;
      b_if.cmd_ra    = 3'd1;
      b_if.cmd_wnr   = 1'b1;
      b_if.cmd_di    = 12'h101;
      step();
      b_if.cmd_ra    = 3'd2;
      b_if.cmd_di    = 12'h202;
      step();
      b_if.cmd_valid = 1'b0;
      ssel_v = '0;
      eoc_v  = '0;
      di1    = '0;
      di2    = '0;
      for (int j = 0; j < 12; j++) begin
         ssel_v[j] = b_if.SSP_SSEL;
         eoc_v[j]  = b_if.SSP_EOC;
         if (j == 2) di1 = b_if.SSP_DI;
         if (j == 7) di2 = b_if.SSP_DI;
         step();
      end
      chk("t6_ssel_pattern", ssel_v, 12'h3DE);
      chk("t6_eoc_pattern", eoc_v, 12'h210);
      chk("t6_di1", di1, 12'h101);
      chk("t6_di2", di2, 12'h202);
      chk("t6_busy", busy_b, 0);
      chk("t6_count", cnt_b, 0);
      chk("t6_no_rsp", b_if.rsp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
